pingpong_wr_ctrl: RTL and testbench

//  Write-side scheduler for the ping-pong buffer. Accepts one valid/ready input stream in the wr_clk domain.

---
 rtl/pingpong_wr_ctrl_pkg.sv | 26 ++
 rtl/pingpong_wr_ctrl.sv | 118 +++++++++++
 tb/tb_pingpong_wr_ctrl.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pingpong_wr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pingpong_wr_ctrl_pkg
//   Shared definitions for the ping-pong buffer controllers (write side and
//   read side): FSM state encodings and a width helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package pingpong_wr_ctrl_pkg;

   // Scheduler states. Encodings are fixed because the read-side controller
   // decodes the same values.
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WR0  = 2'd1;
   localparam logic [1:0] WR1  = 2'd2;

   // Ceiling log2 with a floor of 1, so that a one-word burst still gets a
   // legal one-bit counter.
   function automatic int clog2_min1(input int value);
      int w;
      w = 0;
      while ((64'd1 << w) < 64'(value)) begin
         w = w + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/pingpong_wr_ctrl.sv
// ---------------------------------------------------------------------------
// pingpong_wr_ctrl
//   Write-side scheduler of the ping-pong buffer. Accepts a valid/ready
//   stream and steers bursts of BURST_LEN words alternately into FIFO0 and
//   FIFO1, starting on FIFO0 whenever it leaves IDLE. A full target FIFO
//   stalls the source; the other FIFO is never used out of order.
//
//   Ports
//     wr_clk                  write clock (also the FIFOs' write clock)
//     rst_n                   asynchronous active-low reset
//     enable                  run request; dropping it stops at a burst end
//     din_valid/din/din_ready source handshake
//     fifo0_full/fifo1_full   full flags of the two FIFOs
//     fifo0_wr_en/fifo1_wr_en write strobes, at most one high per cycle
//     fifo_din                write data shared by both FIFOs (= din)
//     sel                     current target FIFO (0/1)
//     busy                    scheduler is in WR0 or WR1
//     burst_done              one-cycle pulse after a burst's last word
//     burst_cnt               completed bursts, wraps silently
// ---------------------------------------------------------------------------
module pingpong_wr_ctrl
   import pingpong_wr_ctrl_pkg::*;
#(
   parameter int DATA_SIZE = 16,
   parameter int BURST_LEN = 8,
   parameter int CNT_W     = 16
) (
   input  logic                 wr_clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 din_valid,
   input  logic [DATA_SIZE-1:0] din,
   output logic                 din_ready,
   input  logic                 fifo0_full,
   input  logic                 fifo1_full,
   output logic                 fifo0_wr_en,
   output logic                 fifo1_wr_en,
   output logic [DATA_SIZE-1:0] fifo_din,
   output logic                 sel,
   output logic                 busy,
   output logic                 burst_done,
   output logic [CNT_W-1:0]     burst_cnt
);

   localparam int                BEAT_W    = clog2_min1(BURST_LEN);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   logic [1:0]        state_reg;
   logic [1:0]        state_next;
   logic [BEAT_W-1:0] beat_reg;
   logic              burst_done_reg;
   logic [CNT_W-1:0]  burst_cnt_reg;

   logic target_full;
   logic accept;
   logic last_beat;

   // The target FIFO is implied by the state: IDLE and WR0 both point at
   // FIFO0, so sel falls back to 0 automatically on entering IDLE.
   assign busy        = (state_reg == WR0) || (state_reg == WR1);
   assign sel         = (state_reg == WR1);

   // Only the target's full flag matters; the other FIFO may be full while
   // it is being drained without affecting this burst.
   assign target_full = sel ? fifo1_full : fifo0_full;
   assign din_ready   = busy & ~target_full;
   assign accept      = din_valid & din_ready;
   assign last_beat   = accept & (beat_reg == LAST_BEAT);

   assign fifo0_wr_en = accept & ~sel;
   assign fifo1_wr_en = accept & sel;
   assign fifo_din    = din;

   assign burst_done  = burst_done_reg;
   assign burst_cnt   = burst_cnt_reg;

   // Burst switching happens only on an accepted last beat, so a falling
   // enable lets the current burst finish before returning to IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (enable)    state_next = WR0;
         WR0:     if (last_beat) state_next = enable ? WR1 : IDLE;
         WR1:     if (last_beat) state_next = enable ? WR0 : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Beat position within the current burst; frozen while stalled.
   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_reg <= '0;
      end else if (accept) begin
         beat_reg <= last_beat ? '0 : beat_reg + 1'b1;
      end
   end

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_done_reg <= 1'b0;
         burst_cnt_reg  <= '0;
      end else begin
         burst_done_reg <= last_beat;
         if (last_beat) begin
            burst_cnt_reg <= burst_cnt_reg + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pingpong_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pingpong_wr_ctrl
//   Bench for pingpong_wr_ctrl. u_dut4 runs with BURST_LEN=4 and is checked
//   by a scoreboard of expected (fifo, data, last-of-burst) entries; u_dut1
//   runs with BURST_LEN=1 on the same inputs for the single-word case.
// ---------------------------------------------------------------------------
module tb_pingpong_wr_ctrl;

   logic        wr_clk;
   logic        rst_n;
   logic        enable;
   logic        din_valid;
   logic [15:0] din;
   logic        fifo0_full;
   logic        fifo1_full;

   logic        ready4, w0_4, w1_4, sel4, busy4, done4;
   logic [15:0] fdin4, cnt4;
   logic        ready1, w0_1, w1_1, sel1, busy1, done1;
   logic [15:0] fdin1, cnt1;

   pingpong_wr_ctrl #(.DATA_SIZE(16), .BURST_LEN(4), .CNT_W(16)) u_dut4 (
      .wr_clk(wr_clk), .rst_n(rst_n), .enable(enable),
      .din_valid(din_valid), .din(din), .din_ready(ready4),
      .fifo0_full(fifo0_full), .fifo1_full(fifo1_full),
      .fifo0_wr_en(w0_4), .fifo1_wr_en(w1_4), .fifo_din(fdin4),
      .sel(sel4), .busy(busy4), .burst_done(done4), .burst_cnt(cnt4)
   );

   pingpong_wr_ctrl #(.DATA_SIZE(16), .BURST_LEN(1), .CNT_W(16)) u_dut1 (
      .wr_clk(wr_clk), .rst_n(rst_n), .enable(enable),
      .din_valid(din_valid), .din(din), .din_ready(ready1),
      .fifo0_full(fifo0_full), .fifo1_full(fifo1_full),
      .fifo0_wr_en(w0_1), .fifo1_wr_en(w1_1), .fifo_din(fdin1),
      .sel(sel1), .busy(busy1), .burst_done(done1), .burst_cnt(cnt1)
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   typedef struct packed {
      logic        fifo;
      logic [15:0] data;
      logic        last;
   } exp_t;

   exp_t        sb_q[$];
   int          checks;
   int          errors;
   int          word_idx;
   logic [15:0] next_data;
   bit          pending;

   // values sampled at the negedge inside step()
   logic        s_acc, s_ready4, s_busy4, s_sel4, s_w0_4, s_w1_4, s_done4;
   logic        s_w0_1, s_w1_1;
   logic [15:0] s_cnt4, s_cnt1;

   // scoreboard monitor for u_dut4
   exp_t        m_e;
   logic        m_exp_done;
   logic [15:0] m_exp_cnt;

   initial begin
      m_exp_done = 1'b0;
      m_exp_cnt  = '0;
   end

   always @(negedge wr_clk) begin
      if (!rst_n) begin
         m_exp_done = 1'b0;
         m_exp_cnt  = '0;
      end else begin
         checks++;
         if (done4 !== m_exp_done) begin
            errors++;
            $display("FAIL sb_burst_done got %b want %b", done4, m_exp_done);
         end
         checks++;
         if (cnt4 !== m_exp_cnt) begin
            errors++;
            $display("FAIL sb_burst_cnt got %0d want %0d", cnt4, m_exp_cnt);
         end
         m_exp_done = 1'b0;
         if (w0_4 && w1_4) begin
            checks++;
            errors++;
            $display("FAIL sb_both_wr_en got 11 want one-hot");
         end else if (w0_4 || w1_4) begin
            checks++;
            if ((w0_4 && fifo0_full) || (w1_4 && fifo1_full)) begin
               errors++;
               $display("FAIL sb_write_full fifo%0d got write want none", w1_4);
            end
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_write fifo%0d data %h want none", w1_4, fdin4);
            end else begin
               m_e = sb_q.pop_front();
               $display("wr fifo%0d data %h last %0b", w1_4, fdin4, m_e.last);
               if (m_e.fifo !== w1_4 || m_e.data !== fdin4) begin
                  errors++;
                  $display("FAIL sb_write got fifo%0d %h want fifo%0d %h",
                           w1_4, fdin4, m_e.fifo, m_e.data);
               end
               if (m_e.last) begin
                  m_exp_done = 1'b1;
                  m_exp_cnt  = m_exp_cnt + 16'd1;
               end
            end
         end
      end
   end

   // One clock of stimulus. A word is pushed to the scoreboard the first
   // time it is offered and stays pending until accepted.
   task automatic step(input bit offer);
      exp_t e;
      if (offer) begin
         if (!pending) begin
            e.fifo = ((word_idx / 4) % 2) == 1;
            e.data = next_data;
            e.last = (word_idx % 4) == 3;
            sb_q.push_back(e);
            pending = 1'b1;
         end
         din       = next_data;
         din_valid = 1'b1;
      end else begin
         din_valid = 1'b0;
      end
      @(negedge wr_clk);
      s_acc    = din_valid & ready4;
      s_ready4 = ready4;
      s_busy4  = busy4;
      s_sel4   = sel4;
      s_w0_4   = w0_4;
      s_w1_4   = w1_4;
      s_done4  = done4;
      s_cnt4   = cnt4;
      s_w0_1   = w0_1;
      s_w1_1   = w1_1;
      s_cnt1   = cnt1;
      @(posedge wr_clk);
      #1;
      if (s_acc) begin
         pending   = 1'b0;
         next_data = next_data + 16'd1;
         word_idx++;
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      enable     = 1'b0;
      din_valid  = 1'b0;
      fifo0_full = 1'b0;
      fifo1_full = 1'b0;
      sb_q.delete();
      pending    = 1'b0;
      word_idx   = 0;
      repeat (2) @(posedge wr_clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      enable     = 1'b1;
      din_valid  = 1'b1;
      din        = 16'hA5A5;
      fifo0_full = 1'b0;
      fifo1_full = 1'b0;
      repeat (2) @(negedge wr_clk);
      checks++;
      if ({ready4, w0_4, w1_4, sel4, busy4, done4} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs4 got %b want 000000", {ready4, w0_4, w1_4, sel4, busy4, done4});
      end
      checks++;
      if (cnt4 !== 16'd0) begin
         errors++;
         $display("FAIL reset_cnt4 got %0d want 0", cnt4);
      end
      checks++;
      if ({ready1, w0_1, w1_1, sel1, busy1, done1} !== 6'b0 || cnt1 !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs1 got %b/%0d want 0/0", {ready1, w0_1, w1_1, sel1, busy1, done1}, cnt1);
      end
      do_reset();
      step(1'b0);
      checks++;
      if (s_busy4 !== 1'b0 || s_ready4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle got busy %b ready %b want 0 0", s_busy4, s_ready4);
      end
      sb_q.delete();
      pending = 1'b0;
   endtask

   task automatic test_basic();
      int  acc_n;
      bit  exp_done;
      do_reset();
      enable   = 1'b1;
      acc_n    = 0;
      exp_done = 1'b0;
      for (int c = 0; c < 40 && acc_n < 8; c++) begin
         step(1'b1);
         checks++;
         if (s_done4 !== exp_done) begin
            errors++;
            $display("FAIL basic_done after %0d words got %b want %b", acc_n, s_done4, exp_done);
         end
         exp_done = s_acc && ((acc_n % 4) == 3);
         if (s_acc) begin
            checks++;
            if (s_w1_4 !== (acc_n >= 4) || s_w0_4 !== (acc_n < 4)) begin
               errors++;
               $display("FAIL basic_route word %0d got w0 %b w1 %b", acc_n, s_w0_4, s_w1_4);
            end
            acc_n++;
         end
      end
      checks++;
      if (acc_n != 8) begin
         errors++;
         $display("FAIL basic_accepted got %0d want 8", acc_n);
      end
      step(1'b0);
      checks++;
      if (s_done4 !== 1'b1 || s_cnt4 !== 16'd2) begin
         errors++;
         $display("FAIL basic_end got done %b cnt %0d want 1 2", s_done4, s_cnt4);
      end
   endtask

   task automatic test_full_stall();
      int acc_n;
      do_reset();
      enable = 1'b1;
      acc_n  = 0;
      for (int c = 0; c < 10 && acc_n < 2; c++) begin
         step(1'b1);
         if (s_acc) acc_n++;
      end
      fifo0_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(1'b1);
         checks++;
         if (s_ready4 !== 1'b0 || s_w0_4 !== 1'b0 || s_w1_4 !== 1'b0) begin
            errors++;
            $display("FAIL stall_cycle%0d got ready %b w0 %b w1 %b want 0 0 0", i, s_ready4, s_w0_4, s_w1_4);
         end
      end
      // release FIFO0; FIFO1 reports full but is not the target
      fifo0_full = 1'b0;
      fifo1_full = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step(1'b1);
         checks++;
         if (s_w0_4 !== 1'b1 || s_w1_4 !== 1'b0) begin
            errors++;
            $display("FAIL stall_resume%0d got w0 %b w1 %b want 1 0", i, s_w0_4, s_w1_4);
         end
      end
      fifo1_full = 1'b0;
      step(1'b1);
      checks++;
      if (s_w1_4 !== 1'b1 || s_w0_4 !== 1'b0) begin
         errors++;
         $display("FAIL stall_switch got w0 %b w1 %b want 0 1", s_w0_4, s_w1_4);
      end
      step(1'b0);
   endtask

   task automatic test_enable_drop();
      int acc_n;
      do_reset();
      enable = 1'b1;
      acc_n  = 0;
      for (int c = 0; c < 12 && acc_n < 5; c++) begin
         step(1'b1);
         if (s_acc) acc_n++;
      end
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         checks++;
         if (s_w1_4 !== 1'b1 || s_busy4 !== 1'b1) begin
            errors++;
            $display("FAIL drop_beat%0d got w1 %b busy %b want 1 1", i + 1, s_w1_4, s_busy4);
         end
      end
      din_valid = 1'b1;
      din       = 16'hDEAD;
      for (int i = 0; i < 2; i++) begin
         @(negedge wr_clk);
         checks++;
         if ({busy4, sel4, ready4, w0_4, w1_4} !== 5'b0) begin
            errors++;
            $display("FAIL drop_idle%0d got %b want 00000", i, {busy4, sel4, ready4, w0_4, w1_4});
         end
         @(posedge wr_clk);
         #1;
      end
      din_valid = 1'b0;
   endtask

   task automatic test_burst_len1();
      int acc_n;
      do_reset();
      enable = 1'b1;
      acc_n  = 0;
      for (int c = 0; c < 20 && acc_n < 6; c++) begin
         step(1'b1);
         if (s_acc) begin
            checks++;
            if (s_w0_1 !== ((acc_n % 2) == 0) || s_w1_1 !== ((acc_n % 2) == 1)) begin
               errors++;
               $display("FAIL len1_word%0d got w0 %b w1 %b", acc_n, s_w0_1, s_w1_1);
            end
            acc_n++;
         end
      end
      step(1'b0);
      checks++;
      if (acc_n != 6 || s_cnt1 !== 16'd6) begin
         errors++;
         $display("FAIL len1_count got words %0d cnt %0d want 6 6", acc_n, s_cnt1);
      end
   endtask

   task automatic test_async_reset();
      int acc_n;
      do_reset();
      enable = 1'b1;
      acc_n  = 0;
      for (int c = 0; c < 15 && acc_n < 6; c++) begin
         step(1'b1);
         if (s_acc) acc_n++;
      end
      // word for beat 2 of WR1 offered directly, then reset mid-cycle
      din_valid = 1'b1;
      din       = next_data;
      #2;
      checks++;
      if (w1_4 !== 1'b1 || sel4 !== 1'b1 || cnt4 !== 16'd1) begin
         errors++;
         $display("FAIL areset_pre got w1 %b sel %b cnt %0d want 1 1 1", w1_4, sel4, cnt4);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ready4, w0_4, w1_4, sel4, busy4, done4} !== 6'b0 || cnt4 !== 16'd0) begin
         errors++;
         $display("FAIL areset_async got %b cnt %0d want 000000 0", {ready4, w0_4, w1_4, sel4, busy4, done4}, cnt4);
      end
      sb_q.delete();
      pending   = 1'b0;
      word_idx  = 0;
      din_valid = 1'b0;
      enable    = 1'b0;
      repeat (2) @(posedge wr_clk);
      #1;
      rst_n  = 1'b1;
      enable = 1'b1;
      acc_n  = 0;
      for (int c = 0; c < 15 && acc_n < 4; c++) begin
         step(1'b1);
         if (s_acc) begin
            if (acc_n == 0) begin
               checks++;
               if (s_w0_4 !== 1'b1 || s_cnt4 !== 16'd0) begin
                  errors++;
                  $display("FAIL areset_first got w0 %b cnt %0d want 1 0", s_w0_4, s_cnt4);
               end
            end
            acc_n++;
         end
      end
      step(1'b0);
      checks++;
      if (s_cnt4 !== 16'd1) begin
         errors++;
         $display("FAIL areset_cnt got %0d want 1", s_cnt4);
      end
   endtask

   task automatic test_random();
      int acc_n;
      bit offer;
      do_reset();
      enable = 1'b1;
      acc_n  = 0;
      for (int c = 0; c < 20000 && acc_n < 1000; c++) begin
         offer      = ($urandom_range(0, 3) != 0);
         fifo0_full = ($urandom_range(0, 3) == 0);
         fifo1_full = ($urandom_range(0, 3) == 0);
         step(offer);
         if (s_acc) begin
            acc_n++;
            checks++;
            if ((s_w0_4 ^ s_w1_4) !== 1'b1) begin
               errors++;
               $display("FAIL rand_strobe got w0 %b w1 %b want one-hot", s_w0_4, s_w1_4);
            end
         end
      end
      fifo0_full = 1'b0;
      fifo1_full = 1'b0;
      step(1'b0);
      checks++;
      if (acc_n != 1000 || sb_q.size() != 0) begin
         errors++;
         $display("FAIL rand_drain got words %0d left %0d want 1000 0", acc_n, sb_q.size());
      end
      checks++;
      if (s_cnt4 !== 16'd250) begin
         errors++;
         $display("FAIL rand_cnt got %0d want 250", s_cnt4);
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      enable     = 1'b0;
      din_valid  = 1'b0;
      din        = '0;
      fifo0_full = 1'b0;
      fifo1_full = 1'b0;
      word_idx   = 0;
      next_data  = 16'h1000;
      pending    = 1'b0;
      test_reset();
      test_basic();
      test_full_stall();
      test_enable_drop();
      test_burst_len1();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
